// File: rtl/calc_pkg.sv
// Shared encodings for the calculator arithmetic sequencer.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_CONV = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int unsigned MAX_OPERAND = 99;

endpackage

// File: rtl/calc_alu_sequencer_bcd_converter.sv
// Sequential double-dabble: binary magnitude to packed BCD digits.
// The load edge performs the first iteration, so RESW edges complete a conversion.
module bcd_converter #(
    parameter int RESW = 14,
    parameter int NDIG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [RESW-1:0]      bin,
    output logic [4*NDIG-1:0]    bcd,
    output logic                 ready
);
    localparam int SRW = 4*NDIG + RESW;
    localparam int CW  = $clog2(RESW + 1);

    logic [SRW-1:0] r_sr;
    logic [CW-1:0]  r_cnt;

    function automatic logic [SRW-1:0] dd_step(input logic [SRW-1:0] sr);
        logic [SRW-1:0] t;
        t = sr;
        for (int d = 0; d < NDIG; d++) begin
            if (t[RESW + 4*d +: 4] >= 4'd5)
                t[RESW + 4*d +: 4] = t[RESW + 4*d +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_sr  <= dd_step({{(4*NDIG){1'b0}}, bin});
            r_cnt <= CW'(1);
        end else if (r_cnt != '0 && r_cnt != CW'(RESW)) begin
            r_sr  <= dd_step(r_sr);
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bcd   = r_sr[SRW-1 -: 4*NDIG];
    assign ready = (r_cnt == CW'(RESW));

endmodule

// File: rtl/calc_alu_sequencer.sv
// Calculator arithmetic controller: add/sub/shift-add multiply, then BCD conversion.
// Result outputs change only on entry to DONE, so the display never sees partial values.
module calc_alu_sequencer
    import calc_pkg::*;
#(
    parameter int OPW  = 7,
    parameter int RESW = 14,
    parameter int NDIG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [OPW-1:0]       a,
    input  logic [OPW-1:0]       b,
    output logic                 busy,
    output logic                 done,
    output logic [RESW-1:0]      result,
    output logic                 neg,
    output logic                 err,
    output logic [4*NDIG-1:0]    bcd
);
    localparam int MCW = $clog2(OPW);

    state_e             r_state, w_next;
    op_e                r_op;
    logic [OPW-1:0]     r_a, r_b;
    logic [RESW-1:0]    r_acc, w_acc_nxt, w_step;
    logic               r_sign, w_sign_nxt;
    logic [MCW-1:0]     r_mcnt;
    logic               r_busy, r_done;
    logic [RESW-1:0]    r_result;
    logic               r_neg, r_err;
    logic [4*NDIG-1:0]  r_bcd;

    logic               w_accept, w_bad, w_conv_load, w_conv_ready;
    logic [4*NDIG-1:0]  w_conv_bcd;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_bad    = (32'(a) > MAX_OPERAND) || (32'(b) > MAX_OPERAND) || (op == OP_RSV);
    assign w_step   = r_b[r_mcnt] ? (RESW'(r_a) << r_mcnt) : '0;

    always_comb begin
        w_next      = r_state;
        w_acc_nxt   = r_acc;
        w_sign_nxt  = r_sign;
        w_conv_load = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) w_next = w_bad ? S_DONE : S_EXEC;
                else          w_next = S_IDLE;
            end
            S_EXEC: begin
                case (r_op)
                    OP_ADD: begin
                        w_acc_nxt   = RESW'(r_a) + RESW'(r_b);
                        w_conv_load = 1'b1;
                    end
                    OP_SUB: begin
                        if (r_a >= r_b) begin
                            w_acc_nxt  = RESW'(r_a - r_b);
                            w_sign_nxt = 1'b0;
                        end else begin
                            w_acc_nxt  = RESW'(r_b - r_a);
                            w_sign_nxt = 1'b1;
                        end
                        w_conv_load = 1'b1;
                    end
                    default: begin
                        w_acc_nxt = r_acc + w_step;
                        if (r_mcnt == MCW'(OPW-1)) w_conv_load = 1'b1;
                    end
                endcase
                if (w_conv_load) w_next = S_CONV;
            end
            S_CONV: if (w_conv_ready) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
            r_mcnt   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_bcd    <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_EXEC) || (w_next == S_CONV);
            r_done  <= (w_next == S_DONE);
            if (w_accept) begin
                r_a    <= a;
                r_b    <= b;
                r_op   <= op_e'(op);
                r_acc  <= '0;
                r_sign <= 1'b0;
                r_mcnt <= '0;
            end else if (r_state == S_EXEC) begin
                r_acc  <= w_acc_nxt;
                r_sign <= w_sign_nxt;
                r_mcnt <= r_mcnt + MCW'(1);
            end
            // Only two ways into DONE: conversion finished, or a rejected request.
            if (w_next == S_DONE) begin
                if (r_state == S_CONV) begin
                    r_result <= r_acc;
                    r_bcd    <= w_conv_bcd;
                    r_neg    <= r_sign;
                    r_err    <= 1'b0;
                end else begin
                    r_result <= '0;
                    r_bcd    <= '0;
                    r_neg    <= 1'b0;
                    r_err    <= 1'b1;
                end
            end
        end
    end

    bcd_converter #(
        .RESW (RESW),
        .NDIG (NDIG)
    ) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_conv_load),
        .bin   (w_acc_nxt),
        .bcd   (w_conv_bcd),
        .ready (w_conv_ready)
    );

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign neg    = r_neg;
    assign err    = r_err;
    assign bcd    = r_bcd;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Scoreboard bench: stimulus queues expected responses, a monitor checks each done pulse.
module tb_calc_alu_sequencer;
    localparam int OPW  = 7;
    localparam int RESW = 14;
    localparam int NDIG = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          op = '0;
    logic [OPW-1:0]      a = '0;
    logic [OPW-1:0]      b = '0;
    logic                busy, done, neg, err;
    logic [RESW-1:0]     result;
    logic [4*NDIG-1:0]   bcd;

    typedef struct {
        string name;
        int    res;
        int    bcdv;
        bit    neg;
        bit    err;
        int    lat;
        int    c0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    calc_alu_sequencer #(.OPW(OPW), .RESW(RESW), .NDIG(NDIG)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .neg    (neg),
        .err    (err),
        .bcd    (bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endtask

    // Drive one request; sampled by the next rising edge.
    task automatic issue(input string nm, input int ia, input int ib, input int iop,
                         input bit push, input int res, input int bcdv,
                         input bit ng, input bit er, input int lat);
        exp_t e;
        a = OPW'(ia);
        b = OPW'(ib);
        op = 2'(iop);
        start = 1'b1;
        if (push) begin
            e.name = nm; e.res = res; e.bcdv = bcdv; e.neg = ng; e.err = er;
            e.lat = lat; e.c0 = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int nbusy);
        int k;
        nbusy = 0;
        k = 0;
        while (!done && k < 60) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done in 60 cycles required done", nm);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run(input string nm, input int ia, input int ib, input int iop,
                       input int res, input int bcdv, input bit ng, input bit er,
                       input int lat, input int exp_busy);
        int nb;
        issue(nm, ia, ib, iop, 1'b1, res, bcdv, ng, er, lat);
        wait_done(nm, nb);
        chk({nm, "/busy_cycles"}, nb, exp_busy);
        idle(2);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 required no pending request");
                end else begin
                    e = q.pop_front();
                    chk({e.name, "/result"},  int'(result), e.res);
                    chk({e.name, "/bcd"},     int'(bcd),    e.bcdv);
                    chk({e.name, "/neg"},     int'(neg),    int'(e.neg));
                    chk({e.name, "/err"},     int'(err),    int'(e.err));
                    chk({e.name, "/latency"}, cyc - e.c0 + 1, e.lat);
                end
            end
        end
    end

    initial begin
        int nb;
        #1 rst_n = 1'b0;
        #2;
        chk("reset/busy", int'(busy), 0);
        chk("reset/done", int'(done), 0);
        chk("reset/result", int'(result), 0);
        chk("reset/bcd", int'(bcd), 0);
        chk("reset/neg_err", int'({neg, err}), 0);
        @(negedge clk); rst_n = 1'b1;
        idle(2);

        run("add23_45",  23, 45, 0,   68, 'h0068, 1'b0, 1'b0, 16, 15);
        run("add99_99",  99, 99, 0,  198, 'h0198, 1'b0, 1'b0, 16, 15);
        run("sub12_57",  12, 57, 1,   45, 'h0045, 1'b1, 1'b0, 16, 15);
        run("sub30_30",  30, 30, 1,    0, 'h0000, 1'b0, 1'b0, 16, 15);
        run("sub99_0",   99,  0, 1,   99, 'h0099, 1'b0, 1'b0, 16, 15);
        run("mul99_99",  99, 99, 2, 9801, 'h9801, 1'b0, 1'b0, 22, 21);
        run("mul0_77",    0, 77, 2,    0, 'h0000, 1'b0, 1'b0, 22, 21);
        run("mul13_11",  13, 11, 2,  143, 'h0143, 1'b0, 1'b0, 22, 21);
        run("err_a100", 100,  5, 0,    0, 'h0000, 1'b0, 1'b1,  1,  0);
        run("err_b100",  99,100, 1,    0, 'h0000, 1'b0, 1'b1,  1,  0);
        run("err_op11",   3,  4, 3,    0, 'h0000, 1'b0, 1'b1,  1,  0);

        // A start while busy must be dropped; a start in the DONE cycle must be taken.
        issue("mul7_8", 7, 8, 2, 1'b1, 56, 'h0056, 1'b0, 1'b0, 22);
        idle(3);
        issue("ignored_add", 1, 1, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        wait_done("mul7_8", nb);
        issue("add2_3_in_done", 2, 3, 0, 1'b1, 5, 'h0005, 1'b0, 1'b0, 16);
        wait_done("add2_3_in_done", nb);
        chk("add2_3_in_done/busy_cycles", nb, 15);
        idle(2);

        // Asynchronous reset in the middle of a conversion.
        issue("rst_victim", 10, 20, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        idle(5);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset/busy", int'(busy), 0);
        chk("midreset/result", int'(result), 0);
        chk("midreset/bcd", int'(bcd), 0);
        chk("midreset/done_neg_err", int'({done, neg, err}), 0);
        @(negedge clk); rst_n = 1'b1;
        idle(2);
        run("add3_4_after_reset", 3, 4, 0, 7, 'h0007, 1'b0, 1'b0, 16, 15);

        idle(4);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
